// File: rtl/cfeb_busy_ctrl_pkg.sv
// Shared widths, FSM encoding and edge-spread window for the CFEB busy sequencer.
package cfeb_busy_ctrl_pkg;

    localparam int unsigned MXCFEB  = 7;
    localparam int unsigned MXKEYB  = 5;
    localparam int unsigned MXKEYBX = 8;
    localparam int unsigned MXDTB   = 4;
    localparam int unsigned MXCNTB  = 16;
    localparam int unsigned CFEBB   = MXKEYBX - MXKEYB;

    // Keys this close to a CFEB boundary may also fire the neighbour
    localparam int unsigned EDGE_LO = 1;
    localparam int unsigned EDGE_HI = 30;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    function automatic logic [MXCNTB-1:0] sat_inc(input logic [MXCNTB-1:0] v);
        return (&v) ? v : v + MXCNTB'(1);
    endfunction

endpackage

// File: rtl/cfeb_deadtime_cnt.sv
// Loadable dead-time down-counter; busy while nonzero.
module cfeb_deadtime_cnt
    import cfeb_busy_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [MXDTB-1:0] load_val,
    output logic             busy
);

    logic [MXDTB-1:0] cnt;

    // A load restarts the count even if it is still running
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - MXDTB'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/cfeb_busy_ctrl.sv
// Accepts the sorter winner into a one-deep trigger register and keeps
// the triggering CFEB (and optionally its edge neighbour) busy for dead_time clocks.
module cfeb_busy_ctrl
    import cfeb_busy_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ttc_resync,
    input  logic [MXDTB-1:0]   dead_time,
    input  logic               spread_en,
    input  logic               sel_vld,
    input  logic [MXKEYBX-1:0] sel_key,
    input  logic               sel_bsy,
    input  logic               out_ready,
    output logic [MXCFEB-1:0]  bsy,
    output logic               trig_vld,
    output logic [MXKEYBX-1:0] trig_key,
    output logic [MXCNTB-1:0]  drop_cnt,
    output logic [MXCNTB-1:0]  err_cnt
);

    localparam int unsigned IDW = CFEBB + 1;

    state_t             state;
    logic               clear;
    logic               cand;
    logic               cfeb_ok;
    logic               accept;
    logic               lo_hit;
    logic               hi_hit;
    logic [CFEBB-1:0]   cfeb_id;
    logic [MXKEYB-1:0]  key;
    logic [MXCFEB-1:0]  load;
    logic [MXCFEB-1:0]  cnt_busy;

    assign clear   = reset | ttc_resync;
    assign cfeb_id = sel_key[MXKEYBX-1:MXKEYB];
    assign key     = sel_key[MXKEYB-1:0];
    assign cand    = sel_vld & ~sel_bsy;
    assign cfeb_ok = cfeb_id < CFEBB'(MXCFEB);
    assign accept  = (state == IDLE) & cand & cfeb_ok;
    assign lo_hit  = spread_en & (key <= MXKEYB'(EDGE_LO)) & (cfeb_id != '0);
    assign hi_hit  = spread_en & (key >= MXKEYB'(EDGE_HI)) & (cfeb_id < CFEBB'(MXCFEB - 1));

    // Counter loads: the winner plus the neighbour across a nearby edge
    always_comb begin
        load = '0;
        for (int i = 0; i < MXCFEB; i++) begin
            load[i] = accept & ((cfeb_id == CFEBB'(i))
                             | (lo_hit & (IDW'(cfeb_id) == IDW'(i + 1)))
                             | (hi_hit & (IDW'(cfeb_id) + IDW'(1) == IDW'(i))));
        end
    end

    for (genvar g = 0; g < MXCFEB; g++) begin : g_cnt
        cfeb_deadtime_cnt u_cnt (
            .clock    (clock),
            .clear    (clear),
            .load     (load[g]),
            .load_val (dead_time),
            .busy     (cnt_busy[g])
        );
    end

    // Everything looks busy to the sorter while an output is pending
    assign bsy = cnt_busy | {MXCFEB{state == PEND}};

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            trig_vld <= 1'b0;
            trig_key <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand) begin
                        if (cfeb_ok) begin
                            trig_key <= sel_key;
                            trig_vld <= 1'b1;
                            state    <= PEND;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                PEND: begin
                    if (cand) begin
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                    if (out_ready) begin
                        trig_vld <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfeb_busy_ctrl.sv
// Directed test of the CFEB busy sequencer: handshake, dead time, edge spread, errors, resync.
module tb_cfeb_busy_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       ttc_resync;
    logic [3:0] dead_time;
    logic       spread_en;
    logic       sel_vld;
    logic [7:0] sel_key;
    logic       sel_bsy;
    logic       out_ready;
    logic [6:0] bsy;
    logic       trig_vld;
    logic [7:0] trig_key;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cfeb_busy_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .ttc_resync (ttc_resync),
        .dead_time  (dead_time),
        .spread_en  (spread_en),
        .sel_vld    (sel_vld),
        .sel_key    (sel_key),
        .sel_bsy    (sel_bsy),
        .out_ready  (out_ready),
        .bsy        (bsy),
        .trig_vld   (trig_vld),
        .trig_key   (trig_key),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    initial forever #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ttc_resync = 1'b0; dead_time = 4'd0; spread_en = 1'b0;
        sel_vld = 1'b0; sel_key = 8'h00; sel_bsy = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_bsy", 32'(bsy), 32'h0);
        chk("rst_vld", 32'(trig_vld), 32'h0);
        chk("rst_key", 32'(trig_key), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);

        // basic accept, cfeb 2
        dead_time = 4'd4; out_ready = 1'b1; sel_vld = 1'b1; sel_key = 8'h45;
        cyc(); sel_vld = 1'b0;
        chk("basic_vld", 32'(trig_vld), 32'h1);
        chk("basic_key", 32'(trig_key), 32'h45);
        chk("basic_bsy_pend", 32'(bsy), 32'h7F);
        cyc();
        chk("basic_vld_clr", 32'(trig_vld), 32'h0);
        chk("basic_bsy1", 32'(bsy), 32'h04);
        cyc(); chk("basic_bsy2", 32'(bsy), 32'h04);
        cyc(); chk("basic_bsy3", 32'(bsy), 32'h04);
        cyc(); chk("basic_bsy_end", 32'(bsy), 32'h00);

        // back-pressure with three dropped candidates
        out_ready = 1'b0; sel_vld = 1'b1; sel_key = 8'h23;
        cyc();
        chk("bp_vld", 32'(trig_vld), 32'h1);
        chk("bp_key", 32'(trig_key), 32'h23);
        chk("bp_bsy", 32'(bsy), 32'h7F);
        sel_key = 8'h61;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_key_hold", 32'(trig_key), 32'h23);
            chk("bp_bsy_hold", 32'(bsy), 32'h7F);
            chk("bp_vld_hold", 32'(trig_vld), 32'h1);
        end
        sel_vld = 1'b0;
        cyc();
        chk("bp_drop", 32'(drop_cnt), 32'h3);
        chk("bp_vld_still", 32'(trig_vld), 32'h1);
        out_ready = 1'b1;
        cyc();
        chk("bp_vld_clr", 32'(trig_vld), 32'h0);
        chk("bp_bsy_clr", 32'(bsy), 32'h00);

        // edge spread to the upper neighbour
        spread_en = 1'b1; dead_time = 4'd3; sel_vld = 1'b1; sel_key = 8'h7F;
        cyc(); sel_vld = 1'b0;
        chk("spr_key", 32'(trig_key), 32'h7F);
        chk("spr_bsy_pend", 32'(bsy), 32'h7F);
        cyc(); chk("spr_bsy1", 32'(bsy), 32'h18);
        cyc(); chk("spr_bsy2", 32'(bsy), 32'h18);
        cyc(); chk("spr_bsy_end", 32'(bsy), 32'h00);
        // cfeb 0, key 0: no lower neighbour exists
        sel_vld = 1'b1; sel_key = 8'h00;
        cyc(); sel_vld = 1'b0;
        chk("spr0_vld", 32'(trig_vld), 32'h1);
        cyc(); chk("spr0_bsy", 32'(bsy), 32'h01);
        cyc(); cyc(); chk("spr0_bsy_end", 32'(bsy), 32'h00);

        // invalid cfeb id
        sel_vld = 1'b1; sel_key = 8'hE2;
        cyc(); sel_vld = 1'b0;
        chk("inv_err", 32'(err_cnt), 32'h1);
        chk("inv_vld", 32'(trig_vld), 32'h0);
        chk("inv_bsy", 32'(bsy), 32'h00);
        // sorter reports all busy
        sel_vld = 1'b1; sel_bsy = 1'b1; sel_key = 8'h45;
        cyc(); sel_vld = 1'b0; sel_bsy = 1'b0;
        chk("sb_vld", 32'(trig_vld), 32'h0);
        chk("sb_bsy", 32'(bsy), 32'h00);
        chk("sb_err", 32'(err_cnt), 32'h1);
        chk("sb_drop", 32'(drop_cnt), 32'h3);

        // re-trigger cfeb 1 three cycles after the first load
        spread_en = 1'b0; dead_time = 4'd6; sel_vld = 1'b1; sel_key = 8'h25;
        cyc(); sel_vld = 1'b0;
        chk("rt_bsy_pend", 32'(bsy), 32'h7F);
        cyc(); chk("rt_bsy1", 32'(bsy), 32'h02);
        cyc();
        sel_vld = 1'b1;
        cyc(); sel_vld = 1'b0;
        chk("rt_bsy_pend2", 32'(bsy), 32'h7F);
        for (int i = 0; i < 5; i++) begin
            cyc(); chk("rt_bsy_ext", 32'(bsy), 32'h02);
        end
        cyc(); chk("rt_bsy_end", 32'(bsy), 32'h00);

        // dead_time 0: busy only while pending
        dead_time = 4'd0; sel_vld = 1'b1; sel_key = 8'h45;
        cyc(); sel_vld = 1'b0;
        chk("dt0_bsy_pend", 32'(bsy), 32'h7F);
        chk("dt0_vld", 32'(trig_vld), 32'h1);
        cyc();
        chk("dt0_bsy", 32'(bsy), 32'h00);
        chk("dt0_vld_clr", 32'(trig_vld), 32'h0);

        // resync during PEND with a counter running
        dead_time = 4'd5; out_ready = 1'b0; sel_vld = 1'b1; sel_key = 8'h65;
        cyc(); sel_vld = 1'b0;
        cyc();
        chk("rs_pre_vld", 32'(trig_vld), 32'h1);
        ttc_resync = 1'b1; sel_vld = 1'b1; sel_key = 8'h45;
        cyc(); ttc_resync = 1'b0; sel_vld = 1'b0;
        chk("rs_vld", 32'(trig_vld), 32'h0);
        chk("rs_key", 32'(trig_key), 32'h0);
        chk("rs_bsy", 32'(bsy), 32'h00);
        chk("rs_drop", 32'(drop_cnt), 32'h0);
        chk("rs_err", 32'(err_cnt), 32'h0);
        dead_time = 4'd2; out_ready = 1'b1; sel_vld = 1'b1; sel_key = 8'h45;
        cyc(); sel_vld = 1'b0;
        chk("rs_acc_vld", 32'(trig_vld), 32'h1);
        chk("rs_acc_key", 32'(trig_key), 32'h45);
        cyc();
        chk("rs_acc_bsy", 32'(bsy), 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfeb_busy_ctrl.md
Name: cfeb_busy_ctrl

Overview:
- Sequencer for the best-of-7 CFEB pattern sorter.
- Takes the sorter's winning candidate (CFEB id in key msbs, busy flag) and accepts it into a one-deep trigger output register with a valid/ready handshake.
- Arms per-CFEB dead-time counters and drives the sorter's bsy0..bsy6 inputs, so a CFEB that just produced a trigger is excluded for a programmable number of clocks.
- Sits between the pattern sorter and the CLCT trigger/sequencer logic.

Parameters:
MXCFEB, 7, number of CFEBs / sorter inputs
MXKEYB, 5, 1/2-strip key width within one CFEB (32 key 1/2-strips)
MXKEYBX, 8, full key width: {cfeb_id[2:0], key[4:0]}
MXDTB, 4, dead-time counter width
MXCNTB, 16, drop/error counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ttc_resync  in  1  synchronous clear of run state; same effect as reset
dead_time  in  MXDTB  dead-time load value, in clocks; 0 disables dead time
spread_en  in  1  also arm the neighbour CFEB when the key is within 2 1/2-strips of a CFEB edge
sel_vld  in  1  sorter output is a trigger candidate this cycle
sel_key  in  MXKEYBX  sorter best key, {cfeb_id, key}
sel_bsy  in  1  sorter best_bsy: all inputs busy, no candidate
out_ready  in  1  downstream accepts trig_key this cycle
bsy  out  MXCFEB  per-CFEB busy flags to sorter bsy0..bsy6
trig_vld  out  1  trig_key holds an accepted candidate
trig_key  out  MXKEYBX  accepted key, stable while trig_vld=1
drop_cnt  out  MXCNTB  saturating count of candidates dropped in PEND
err_cnt  out  MXCNTB  saturating count of candidates with cfeb_id >= MXCFEB

Behaviour:
- Reset values (reset or ttc_resync asserted at a clock edge):
  - bsy=0, trig_vld=0, trig_key=0, drop_cnt=0, err_cnt=0.
  - All dead-time counters=0; FSM=IDLE.
  - Reset/resync overrides every other event in the same cycle.
- Candidate: cand = sel_vld & !sel_bsy. Candidate cfeb_id c = sel_key[7:5], local key k = sel_key[4:0].
- FSM, two states: IDLE, PEND.
- IDLE, cand with c < MXCFEB (accept):
  - Register trig_key=sel_key and trig_vld=1 at the next edge (latency 1).
  - Load cnt[c]=dead_time.
  - If spread_en and k<=1 and c>0, also load cnt[c-1]=dead_time.
  - If spread_en and k>=30 and c<MXCFEB-1, also load cnt[c+1]=dead_time.
  - Next state is PEND.
- IDLE, cand with c >= MXCFEB: not accepted; err_cnt+1 (saturating); stay IDLE.
- PEND:
  - trig_vld=1 and trig_key held stable.
  - On out_ready=1: trig_vld clears at the next edge; next state IDLE.
  - Every cand arriving in PEND is dropped and drop_cnt+1 (saturating), including a cand in the same cycle as out_ready.
  - Counters are not loaded for dropped candidates.
- bsy[i] = (cnt[i]!=0) | (state==PEND). Registered-state based, combinational from state/counters.
  - The sorter therefore sees everything busy while an output is pending.
- Counters:
  - Each cycle, a nonzero counter decrements by 1; a zero counter holds.
  - A load takes precedence over decrement. A re-load of a nonzero counter restarts it at dead_time.
  - Result: sel_vld accepted at edge N gives bsy[c] from N+1 for max(dead_time,1) cycles, the PEND term included. Counter-only busy lasts dead_time cycles.
- dead_time is sampled only at load; changes mid-count do not affect running counters.
- Saturating counters stop at all-ones.
- Simultaneous out_ready and new cand in PEND: handshake completes, cand dropped. There is no same-cycle re-accept; throughput is at most 1 trigger per 2 clocks.

Decomposition:
- Shared package/include (pattern_params): MXCFEB, MXKEYB, MXKEYBX, MXDTB, MXCNTB; state encodings IDLE=0, PEND=1; edge-spread window constants EDGE_LO=1, EDGE_HI=30.
- One sub-module, cfeb_deadtime_cnt: one loadable down-counter with a busy output. Instantiated MXCFEB times via generate.

Test Plan:
- Basic accept: dead_time=4, out_ready=1 held, sel_vld=1 with key 8'h45 (cfeb 2, k=5) for one cycle -> trig_vld=1 and trig_key=8'h45 the next cycle for 1 cycle; bsy=7'b0000100 for exactly 4 cycles, then 0.
- Back-pressure: out_ready=0 for 5 cycles after an accept, 3 cands offered -> bsy=7'h7F throughout PEND, trig_key stable, drop_cnt=3; when out_ready=1, trig_vld drops next cycle.
- Edge spread: spread_en=1, dead_time=3, key {3'd3,5'd31} -> bsy=7'b0011000 for 3 cycles. Key {3'd0,5'd0} -> only bsy[0] (no cfeb -1).
- Invalid and busy: key {3'd7,5'd2} -> err_cnt=1, no trig_vld. sel_vld=1 with sel_bsy=1 -> no change to any output.
- Re-trigger and dead_time=0: accept on cfeb 1 with dead_time=6, then another cfeb-1 accept after 3 cycles -> bsy[1] extends to 6 cycles from the second load. With dead_time=0, bsy is high only during PEND.
- Reset/resync mid-operation: ttc_resync during PEND with counters running -> next cycle all outputs 0, state IDLE; a cand in the following cycle is accepted normally.
